sub100_pipe: RTL and testbench

SUB100_PIPE -- requirements
Module: sub100_pipe

---
 rtl/adder_pkg.sv | 6 +
 rtl/cla_slice.sv | 42 ++++
 rtl/sub100_pipe.sv | 102 ++++++++++
 tb/tb_sub100_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared defaults for the wide adder/subtractor family (sub100_pipe, Adder100).
package adder_pkg;
  localparam int DEF_WIDTH = 100;
  localparam int DEF_SEG   = 25;
  localparam int DEF_NSEG  = DEF_WIDTH / DEF_SEG;
endpackage

// File: rtl/cla_slice.sv
// Combinational SEG-bit carry-lookahead adder: sum = a + b + cin.
module cla_slice #(
  parameter int SEG = 25
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);
  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is built directly from generate/propagate terms, so no carry
  // depends on a previously computed carry (flat lookahead, no ripple).
  always_comb begin
    logic acc;
    logic term;
    acc  = 1'b0;
    term = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      term = cin;
      for (int m = 0; m <= i; m++) term = term & p[m];
      acc = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign sum  = p ^ c[SEG-1:0];
  assign cout = c[SEG];
endmodule

// File: rtl/sub100_pipe.sv
// Pipelined wide subtractor: diff = a - b - bin computed as a + ~b + ~bin,
// one SEG-bit lookahead slice resolved per stage, carry registered between
// stages. Whole pipeline stalls when the output is held by backpressure.
module sub100_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int NSEG = WIDTH / SEG;

  // Index 0 is the operand register loaded on acceptance; stage k reads
  // register k and writes register k+1. Register NSEG is the output.
  logic [NSEG:0]                 vld_pipe_q, vld_pipe_d;
  logic [NSEG:0]                 cy_q, cy_d;
  logic [NSEG:0][WIDTH-1:0]      dif_q, dif_d;
  logic [NSEG-1:0][WIDTH-1:0]    opa_q, opa_d;
  logic [NSEG-1:0][WIDTH-1:0]    opb_q, opb_d;

  logic [NSEG-1:0][SEG-1:0]      sum;
  logic [NSEG-1:0]               cout;
  logic                          adv;

  // Slice k of the operands is resolved in stage k; b is inverted here so
  // the registered operands stay in their original form.
  for (genvar k = 0; k < NSEG; k++) begin : g_slice
    cla_slice #(.SEG(SEG)) u_slice (
      .a    (opa_q[k][k*SEG +: SEG]),
      .b    (~opb_q[k][k*SEG +: SEG]),
      .cin  (cy_q[k]),
      .sum  (sum[k]),
      .cout (cout[k])
    );
  end

  // The last operand register only feeds its top slice; fold the rest away.
  logic unused_ok;
  assign unused_ok = ^{opa_q[NSEG-1], opb_q[NSEG-1]};

  // The only stall source is a held output; reset forces ready high.
  assign adv      = !(vld_pipe_q[NSEG] && !out_ready);
  assign in_ready = rst || adv;

  assign out_valid = vld_pipe_q[NSEG];
  assign diff      = dif_q[NSEG];
  assign bout      = ~cy_q[NSEG];

  // Next-state: hold everything on stall, otherwise shift every stage by one.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    cy_d       = cy_q;
    dif_d      = dif_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    if (adv) begin
      vld_pipe_d[0] = in_valid;
      opa_d[0]      = a;
      opb_d[0]      = b;
      cy_d[0]       = ~bin;
      dif_d[0]      = '0;
      for (int k = 0; k < NSEG; k++) begin
        vld_pipe_d[k+1]              = vld_pipe_q[k];
        cy_d[k+1]                    = cout[k];
        dif_d[k+1]                   = dif_q[k];
        dif_d[k+1][k*SEG +: SEG]     = sum[k];
      end
      for (int k = 1; k < NSEG; k++) begin
        opa_d[k] = opa_q[k-1];
        opb_d[k] = opb_q[k-1];
      end
    end
  end

  // Pipeline registers; carry resets to 1 so bout reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      cy_q       <= '1;
      dif_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      cy_q       <= cy_d;
      dif_q      <= dif_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
    end
  end
endmodule

// File: tb/tb_sub100_pipe.sv
// Scoreboard bench for sub100_pipe.
module tb_sub100_pipe;
  localparam int W = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W:0] exp_q[$];

  sub100_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic bi);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (diff !== '0 || bout !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: got diff=%h bout=%b want 0/0", diff, bout);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
    end
  endtask

  // One operand set through an idle pipeline: checks latency, value, single delivery.
  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                         input string nm);
    logic [W:0] e;
    int cyc;
    @(negedge clk);
    a = x; b = y; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(model(x, y, bi));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (!out_valid && cyc < 12);
    n_cmp++;
    if (cyc != 4) begin
      n_bad++; $display("FAIL %s_latency: got %0d cycles want 4", nm, cyc);
    end
    if (!out_valid) begin
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (diff !== e[W-1:0]) begin
      n_bad++; $display("FAIL %s_diff: got %h want %h", nm, diff, e[W-1:0]);
    end
    n_cmp++;
    if (bout !== e[W]) begin
      n_bad++; $display("FAIL %s_bout: got %b want %b", nm, bout, e[W]);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL %s_single: out_valid got %b want 0 after delivery", nm, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] top;
    top = '0;
    top[W-1] = 1'b1;
    run_one('0, '0, 1'b0, "zero");
    run_one('0, {{(W-1){1'b0}}, 1'b1}, 1'b0, "full_borrow");
    run_one({{(W-3){1'b0}}, 3'd5}, {{(W-2){1'b0}}, 2'd3}, 1'b1, "small");
    run_one(top, '0, 1'b1, "cross_slice");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sa[6];
    logic [W-1:0] sb[6];
    logic         sbi[6];
    logic [W:0]   e;
    logic [W:0]   held;
    logic         stalled_prev;
    int idx, nrecv, cyc, nstall;
    for (int i = 0; i < 6; i++) begin
      sa[i] = rnd(); sb[i] = rnd(); sbi[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; nrecv = 0; cyc = 0; nstall = 0; stalled_prev = 1'b0; held = '0;
    while (nrecv < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (idx < 6) begin
        a = sa[idx]; b = sb[idx]; bin = sbi[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {bout, diff} !== held) begin
          n_bad++;
          $display("FAIL b2b_hold: got v=%b %h want v=1 %h", out_valid, {bout, diff}, held);
        end
      end
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++; $display("FAIL b2b_in_ready_stall: got %b want 0", in_ready);
        end
        stalled_prev = 1'b1;
        held = {bout, diff};
        nstall++;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra: got %h want nothing", {bout, diff});
        end else begin
          e = exp_q.pop_front();
          if ({bout, diff} !== e) begin
            n_bad++; $display("FAIL b2b_result%0d: got %h want %h", nrecv, {bout, diff}, e);
          end
        end
        nrecv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        idx++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (nrecv != 6 || idx != 6) begin
      n_bad++; $display("FAIL b2b_count: got %0d out/%0d in want 6/6", nrecv, idx);
    end
    n_cmp++;
    if (nstall < 1) begin
      n_bad++; $display("FAIL b2b_stall_seen: got %0d stall cycles want >=1", nstall);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_flush();
    int seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = rnd(); b = rnd(); bin = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL flush_dropped: got %0d valid cycles want 0", seen);
    end
    run_one({{(W-4){1'b0}}, 4'd10}, {{(W-3){1'b0}}, 3'd4}, 1'b0, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
